// File: rtl/arith_pkg.sv
// Shared types for the arithmetic issue queue: datapath width, opcode and request payload.
package arith_pkg;

  localparam int DATA_W = 32;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } arith_op_t;

  typedef struct packed {
    arith_op_t         op;
    logic [DATA_W-1:0] opa;
    logic [DATA_W-1:0] opb;
  } arith_req_t;

endpackage

// File: rtl/arith_issue_queue_if.sv
// Request and result handshakes of the arithmetic issue queue; the queue uses the slave side.
interface arith_issue_queue_if #(
  parameter int TAG_W = 4
);
  import arith_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic              in_op;
  logic [DATA_W-1:0] in_opa;
  logic [DATA_W-1:0] in_opb;
  logic [TAG_W-1:0]  in_tag;

  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;
  logic [TAG_W-1:0]  res_tag;
  logic              res_ovf;

  modport master (
    output in_valid, in_op, in_opa, in_opb, in_tag, res_ready,
    input  in_ready, res_valid, res_data, res_tag, res_ovf
  );

  modport slave (
    input  in_valid, in_op, in_opa, in_opb, in_tag, res_ready,
    output in_ready, res_valid, res_data, res_tag, res_ovf
  );

endinterface

// File: rtl/arith_req_fifo.sv
// Synchronous circular-buffer FIFO with occupancy count; storage is not reset, only control state.
module arith_req_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [W-1:0]           wdata_i,
  output logic [W-1:0]           rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/arith_issue_queue.sv
// Buffers add/sub requests, drives the head operands to the external adder/subtractor and registers
// the selected result into a valid/ready slot. Define ARITH_ISSUE_OVF_EN to capture signed overflow.
module arith_issue_queue
  import arith_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  arith_issue_queue_if.slave     bus,
  output logic [DATA_W-1:0]      a,
  output logic [DATA_W-1:0]      b,
  input  logic [DATA_W-1:0]      sum,
  output logic [DATA_W-1:0]      x,
  output logic [DATA_W-1:0]      y,
  input  logic [DATA_W-1:0]      sub,
  output logic [$clog2(DEPTH):0] count
);

  typedef struct packed {
    arith_req_t       req;
    logic [TAG_W-1:0] tag;
  } entry_t;

  entry_t            wr_entry;
  entry_t            head;
  logic              full, empty, push, issue;
  logic [DATA_W-1:0] result;

  logic              res_valid_q, res_valid_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic [TAG_W-1:0]  res_tag_q, res_tag_d;

  always_comb begin
    wr_entry.req.op  = arith_op_t'(bus.in_op);
    wr_entry.req.opa = bus.in_opa;
    wr_entry.req.opb = bus.in_opb;
    wr_entry.tag     = bus.in_tag;
  end

  // in_ready depends only on FIFO state, never on res_ready.
  assign bus.in_ready = !full;
  assign push         = bus.in_valid && !full;
  assign issue        = !empty && (!res_valid_q || bus.res_ready);

  arith_req_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(entry_t))
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (issue),
    .wdata_i (wr_entry),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  assign a = empty ? '0 : head.req.opa;
  assign b = empty ? '0 : head.req.opb;
  assign x = empty ? '0 : head.req.opa;
  assign y = empty ? '0 : head.req.opb;

  assign result = (head.req.op == OP_SUB) ? sub : sum;

  // Result slot: reload on issue, otherwise drain on consumer handshake.
  always_comb begin
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_tag_d   = res_tag_q;
    if (issue) begin
      res_valid_d = 1'b1;
      res_data_d  = result;
      res_tag_d   = head.tag;
    end else if (bus.res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_tag_q   <= '0;
    end else begin
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_tag_q   <= res_tag_d;
    end
  end

  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_tag   = res_tag_q;

`ifdef ARITH_ISSUE_OVF_EN
  function automatic logic ovf_calc(input arith_op_t op, input logic [DATA_W-1:0] opa,
                                    input logic [DATA_W-1:0] opb, input logic [DATA_W-1:0] r);
    logic sa, sb, sr;
    sa = opa[DATA_W-1];
    sb = opb[DATA_W-1];
    sr = r[DATA_W-1];
    if (op == OP_SUB) return (sa != sb) && (sr != sa);
    return (sa == sb) && (sr != sa);
  endfunction

  logic res_ovf_q, res_ovf_d;

  always_comb begin
    res_ovf_d = res_ovf_q;
    if (issue) res_ovf_d = ovf_calc(head.req.op, head.req.opa, head.req.opb, result);
  end

  always_ff @(posedge clk) begin
    if (rst) res_ovf_q <= 1'b0;
    else     res_ovf_q <= res_ovf_d;
  end

  assign bus.res_ovf = res_ovf_q;
`else
  assign bus.res_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_arith_issue_queue.sv
// Directed scoreboard bench for arith_issue_queue with behavioural adder/subtractor models.
module tb_arith_issue_queue;
  import arith_pkg::*;

  localparam int DEPTH = 4;
  localparam int TAG_W = 4;
`ifdef ARITH_ISSUE_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  arith_issue_queue_if #(.TAG_W(TAG_W)) bus ();

  logic [31:0]              a, b, x, y, sum, sub;
  logic [$clog2(DEPTH):0]   count;

  assign sum = a + b;
  assign sub = x - y;

  arith_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .a     (a),
    .b     (b),
    .sum   (sum),
    .x     (x),
    .y     (y),
    .sub   (sub),
    .count (count)
  );

  typedef struct {
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
    logic             ovf;
  } exp_t;

  exp_t sb[$];
  exp_t nx;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   n_results = 0;

  function automatic exp_t model(input logic op, input logic [31:0] p, input logic [31:0] q,
                                 input logic [TAG_W-1:0] t);
    exp_t e;
    logic [31:0] r;
    r = op ? (p - q) : (p + q);
    e.data = r;
    e.tag  = t;
    e.ovf  = 1'b0;
    if (OVF_ON)
      e.ovf = op ? ((p[31] != q[31]) && (r[31] != p[31])) : ((p[31] == q[31]) && (r[31] != p[31]));
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, expv);
    end
  endtask

  task automatic drive(input logic op, input logic [31:0] p, input logic [31:0] q,
                       input logic [TAG_W-1:0] t);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_opa   = p;
    bus.in_opb   = q;
    bus.in_tag   = t;
    nx = model(op, p, q, t);
  endtask

  // Observe handshakes mid-cycle, then advance past the next rising edge.
  task automatic tick(output bit acc);
    exp_t e;
    @(negedge clk);
    if (!rst && bus.res_valid && bus.res_ready) begin
      n_results++;
      chk("result_expected", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("res_data", 64'(bus.res_data), 64'(e.data));
        chk("res_tag", 64'(bus.res_tag), 64'(e.tag));
        chk("res_ovf", 64'(bus.res_ovf), 64'(e.ovf));
      end
    end
    acc = !rst && bus.in_valid && bus.in_ready;
    if (acc) sb.push_back(nx);
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    bit acc;
    bus.in_valid  = 1'b0;
    bus.res_ready = 1'b1;
    for (int i = 0; i < 60 && (sb.size() != 0 || bus.res_valid); i++) tick(acc);
    chk({name, "_drained"}, 64'(sb.size()), 64'd0);
    chk({name, "_res_valid_idle"}, 64'(bus.res_valid), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int nacc, idx, cyc, r0;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_op = 1'b0; bus.in_opa = '0; bus.in_opb = '0; bus.in_tag = '0;
    bus.res_ready = 1'b0;
    nx = model(1'b0, 32'd0, 32'd0, '0);
    tick(acc); tick(acc);
    rst = 1'b0;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_res_valid", 64'(bus.res_valid), 64'd0);
    chk("rst_res_data", 64'(bus.res_data), 64'd0);
    chk("rst_res_ovf", 64'(bus.res_ovf), 64'd0);
    chk("rst_operands", 64'({a, b} | {x, y}), 64'd0);

    // Single add: accepted at edge N, visible after edge N+1.
    bus.res_ready = 1'b1;
    drive(1'b0, 32'd1, 32'd2, 4'd3);
    nx.data = 32'd3; nx.ovf = 1'b0;
    tick(acc);
    bus.in_valid = 1'b0;
    chk("add_accepted", 64'(acc), 64'd1);
    chk("add_not_yet_valid", 64'(bus.res_valid), 64'd0);
    chk("add_count", 64'(count), 64'd1);
    chk("add_operand_a", 64'(a), 64'd1);
    chk("add_operand_y", 64'(y), 64'd2);
    tick(acc);
    chk("add_valid", 64'(bus.res_valid), 64'd1);
    chk("add_data", 64'(bus.res_data), 64'd3);
    chk("add_tag", 64'(bus.res_tag), 64'd3);
    drain("add");

    // Subtract, including borrow wrap.
    drive(1'b1, 32'd9, 32'd3, 4'd4);
    nx.data = 32'd6; nx.ovf = 1'b0;
    tick(acc);
    drive(1'b1, 32'd0, 32'd1, 4'd5);
    nx.data = 32'hFFFF_FFFF; nx.ovf = 1'b0;
    tick(acc);
    drain("sub");

    // Back-pressure fill: FIFO plus result slot.
    bus.res_ready = 1'b0;
    nacc = 0;
    for (int i = 0; i < 10; i++) begin
      drive(i[0], $urandom, $urandom, TAG_W'(i + 6));
      tick(acc);
      if (acc) nacc++;
    end
    bus.in_valid = 1'b0;
    chk("bp_accepted", 64'(nacc), 64'd5);
    chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
    chk("bp_count", 64'(count), 64'd4);
    chk("bp_slot_tag", 64'(bus.res_tag), 64'd6);
    tick(acc);
    chk("bp_slot_held", 64'(bus.res_tag), 64'd6);
    bus.res_ready = 1'b1;
    tick(acc);
    chk("bp_in_ready_back", 64'(bus.in_ready), 64'd1);
    chk("bp_count_after_pop", 64'(count), 64'd3);
    for (int j = 0; j < 4; j++) begin
      chk("bp_stream_valid", 64'(bus.res_valid), 64'd1);
      tick(acc);
    end
    chk("bp_all_out", 64'(sb.size()), 64'd0);
    chk("bp_idle", 64'(bus.res_valid), 64'd0);

    // Wrap-around with toggling consumer.
    r0 = n_results;
    idx = 0; cyc = 0;
    while (idx < 10 && cyc < 200) begin
      drive(idx[1], $urandom, $urandom, TAG_W'(idx));
      bus.res_ready = cyc[0];
      tick(acc);
      if (acc) idx++;
      cyc++;
    end
    chk("wrap_sent", 64'(idx), 64'd10);
    drain("wrap");
    chk("wrap_results", 64'(n_results - r0), 64'd10);

    // Signed overflow corners.
    bus.res_ready = 1'b1;
    drive(1'b0, 32'h7FFF_FFFF, 32'd1, 4'd1);
    nx.data = 32'h8000_0000; nx.ovf = OVF_ON;
    tick(acc);
    drive(1'b0, 32'hFFFF_FFFF, 32'd1, 4'd2);
    nx.data = 32'd0; nx.ovf = 1'b0;
    tick(acc);
    drive(1'b1, 32'h8000_0000, 32'd1, 4'd3);
    nx.data = 32'h7FFF_FFFF; nx.ovf = OVF_ON;
    tick(acc);
    drain("ovf");

    // Reset with entries queued and a full result slot.
    bus.res_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 32'(i), 32'd100, TAG_W'(i + 9));
      tick(acc);
    end
    bus.in_valid = 1'b0;
    chk("mid_count", 64'(count), 64'd3);
    chk("mid_res_valid", 64'(bus.res_valid), 64'd1);
    rst = 1'b1;
    tick(acc);
    rst = 1'b0;
    sb.delete();
    chk("mrst_count", 64'(count), 64'd0);
    chk("mrst_res_valid", 64'(bus.res_valid), 64'd0);
    chk("mrst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("mrst_res_data", 64'(bus.res_data), 64'd0);
    chk("mrst_res_tag", 64'(bus.res_tag), 64'd0);
    chk("mrst_operands", 64'({a, b} | {x, y}), 64'd0);
    bus.res_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(acc);
      chk("mrst_no_stale", 64'(bus.res_valid), 64'd0);
    end
    drive(1'b0, 32'd5, 32'd6, 4'd7);
    nx.data = 32'd11; nx.ovf = 1'b0;
    tick(acc);
    drain("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/arith_issue_queue.md
# arith_issue_queue

Operand-buffering issue stage that sits directly upstream of the combinational `adder` and `subtractor` units. It accepts add/sub requests over a valid/ready handshake and buffers them in a small FIFO. It drives the head entry's operands onto both units and registers the selected result into a valid/ready output slot. This turns the two combinational datapaths into a pipelined, back-pressurable arithmetic service.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `TAG_W`, 4: width of the request tag carried unchanged to the result.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: request present.
- `in_ready` out 1: request accepted when `in_valid && in_ready`.
- `in_op` in 1: 0 = add, 1 = subtract.
- `in_opa` in 32: first operand (addend / minuend).
- `in_opb` in 32: second operand (addend / subtrahend).
- `in_tag` in TAG_W: request ID.
- `a`, `b` out 32: adder operands.
- `sum` in 32: adder result.
- `x`, `y` out 32: subtractor operands.
- `sub` in 32: subtractor result.
- `res_valid` out 1: result slot full.
- `res_ready` in 1: consumer takes result when `res_valid && res_ready`.
- `res_data` out 32: selected result.
- `res_tag` out TAG_W: tag of result.
- `res_ovf` out 1: signed overflow flag; see Configuration.
- `count` out $clog2(DEPTH)+1: FIFO occupancy, excluding the result slot.

## Operation
- **FIFO.** Circular buffer of {op, opa, opb, tag} with wrapping read/write pointers and an occupancy counter.
  - `in_ready = (count != DEPTH)`.
  - `in_ready` is registered-state only, with no combinational path from `res_ready`.
- **Operand drive.**
  - `a = x = head.opa` and `b = y = head.opb` whenever the FIFO is non-empty.
  - All four are 0 when the FIFO is empty.
- **Issue.** Condition: `issue = (count != 0) && (!res_valid || res_ready)`.
  - On an issue edge, pop the head.
  - Load `res_data = head.op ? sub : sum`, `res_tag = head.tag` and `res_ovf`.
  - Set `res_valid = 1`.
- **Drain.** On `res_valid && res_ready` with no issue, clear `res_valid`.
- **Simultaneous push and pop.** Both happen; `count` is unchanged; the pointers advance independently.
- **Empty case.** A push into an empty FIFO is not issued in the same cycle; there is no bypass.
- **Arithmetic.** Modulo 2^32; carries and borrows are discarded.
- **Reset.** `rst` at any edge, including mid-operation:
  - pointers = 0, `count` = 0, `res_valid` = 0, `res_data` = 0, `res_tag` = 0, `res_ovf` = 0;
  - in-flight entries are discarded.
- **Reset values of outputs.** `in_ready` = 1 and `a`/`b`/`x`/`y` = 0 follow from the cleared state.

## Timing
- Request accepted at edge N → earliest `res_valid` = 1 after edge N+1 (2-cycle latency).
- With `res_ready` held at 1, throughput is one result per cycle.
- `res_*` outputs are stable while `res_valid && !res_ready`.
- Both units are combinational; the operand-to-capture path is one cycle.
- Maximum buffered with `res_ready = 0`: DEPTH + 1 requests (FIFO plus result slot).

## Configuration
- **Macro:** `ARITH_ISSUE_OVF_EN`.
- **Defined:** `res_ovf` is captured with the result.
  - Add: `opa[31]==opb[31] && sum[31]!=opa[31]`.
  - Sub: `opa[31]!=opb[31] && sub[31]!=opa[31]`.
- **Undefined:** the `res_ovf` port stays present and is tied to 0; no overflow logic is synthesised.

## Structure
- Package `arith_pkg` holds:
  - `localparam DATA_W = 32`;
  - `typedef enum logic {OP_ADD, OP_SUB} arith_op_t`;
  - the request struct `arith_req_t` {op, opa, opb}.
  - The tag is appended locally, since it is sized by `TAG_W`.
- One sub-module: `arith_req_fifo`, a parameterised synchronous FIFO with push/pop, full/empty and count.
- Issue logic and the result slot stay in `arith_issue_queue`.

## Test plan
- **Single add.** Push add 1, 2, tag 3, with `res_ready` = 1 → `res_valid` 2 cycles later, `res_data` = 3, `res_tag` = 3, `res_ovf` = 0.
- **Single sub.** Push sub 9, 3 → `res_data` = 6; then sub 0, 1 → `res_data` = 0xFFFFFFFF.
- **Back-pressure.** Hold `res_ready` = 0 and push continuously → exactly 5 accepted, then `in_ready` = 0 and `count` = 4.
  - Release `res_ready` → 5 results in order, one per cycle.
  - `in_ready` returns to 1 the cycle after the first pop.
- **Wrap-around.** Stream 10 requests through DEPTH = 4 with `res_ready` toggling → tags delivered in order and no loss.
- **Overflow (macro defined).**
  - add 0x7FFFFFFF + 1 → 0x80000000, `res_ovf` = 1.
  - add 0xFFFFFFFF + 1 → 0, `res_ovf` = 0.
  - sub 0x80000000 − 1 → 0x7FFFFFFF, `res_ovf` = 1.
  - Without the macro, `res_ovf` = 0 for all three.
- **Reset mid-operation.** With 3 entries queued and `res_valid` = 1, assert `rst` for one cycle → next cycle `count` = 0, `res_valid` = 0, `in_ready` = 1, and no stale result emerges.
